// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner. Bus writes land in staging registers, which are
// committed to the displayed copy only at frame wrap. Adds dp/blank/blink masks and PWM.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int SCAN_W       = 8,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic [1:0]        addr,
  input  logic [31:0]       wdata,
  output logic [7:0]        o_seg,
  output logic [DIGITS-1:0] o_sel,
  output logic              frame_done
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [2:0]        LAST_IDX   = 3'(DIGITS - 1);
  localparam logic [BW-1:0]     LAST_BLINK = BW'(BLINK_FRAMES - 1);
  localparam logic [7:0]        SEG_OFF    = {8{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF    = {DIGITS{ACTIVE_LOW}};

  logic [SCAN_W-1:0] pre;
  logic [2:0]        idx;
  logic              tick;
  logic              wrap;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;

  logic [4*DIGITS-1:0] data_stg, data_act;
  logic [DIGITS-1:0]   dp_stg, dp_act;
  logic [DIGITS-1:0]   blank_stg, blank_act;
  logic [DIGITS-1:0]   blink_stg, blink_act;
  logic [2:0]          bright_stg, bright_act;

  logic [31:0] data_pad;
  logic [7:0]  dp_pad, blank_pad, blink_pad;
  logic [3:0]  nibble;
  logic        digit_on;
  logic [7:0]  seg_al, sel_al, seg_next, sel_full;
  logic [DIGITS-1:0] sel_next;
  logic        unused_bits;

  // Active-low glyph for segments {g,f,e,d,c,b,a}; dp is handled separately.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign tick = &pre;
  assign wrap = tick && (idx == LAST_IDX);

  // Padding to the 8-digit maximum keeps the 3-bit idx a legal index for any DIGITS.
  assign data_pad  = 32'(data_act);
  assign dp_pad    = 8'(dp_act);
  assign blank_pad = 8'(blank_act);
  assign blink_pad = 8'(blink_act);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
      idx <= 3'd0;
    end else begin
      pre <= pre + 1'b1;
      if (tick) idx <= wrap ? 3'd0 : idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_stg   <= '0;
      dp_stg     <= '0;
      blank_stg  <= '0;
      bright_stg <= 3'd7;
      blink_stg  <= '0;
    end else if (cs) begin
      case (addr)
        2'd0: data_stg  <= wdata[4*DIGITS-1:0];
        2'd1: dp_stg    <= wdata[DIGITS-1:0];
        2'd2: blank_stg <= wdata[DIGITS-1:0];
        default: begin
          bright_stg <= wdata[2:0];
          blink_stg  <= wdata[8 +: DIGITS];
        end
      endcase
    end
  end

  // A write on the commit edge only reaches staging; the old staging value commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_act   <= '0;
      dp_act     <= '0;
      blank_act  <= '0;
      bright_act <= 3'd7;
      blink_act  <= '0;
    end else if (wrap) begin
      data_act   <= data_stg;
      dp_act     <= dp_stg;
      blank_act  <= blank_stg;
      bright_act <= bright_stg;
      blink_act  <= blink_stg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == LAST_BLINK) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Top three prescaler bits form the PWM ramp compared against brightness.
  always_comb begin
    nibble   = data_pad[{idx, 2'b00} +: 4];
    digit_on = !blank_pad[idx] && !(blink_pad[idx] && blink_phase) &&
               (pre[SCAN_W-1 -: 3] <= bright_act);
    seg_al   = 8'hFF;
    sel_al   = 8'hFF;
    if (digit_on) begin
      seg_al = {~dp_pad[idx], hex_glyph(nibble)};
      sel_al = ~(8'b1 << idx);
    end
    seg_next = ACTIVE_LOW ? seg_al : ~seg_al;
    sel_full = ACTIVE_LOW ? sel_al : ~sel_al;
    sel_next = sel_full[DIGITS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_seg      <= SEG_OFF;
      o_sel      <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      o_seg      <= seg_next;
      o_sel      <= sel_next;
      frame_done <= wrap;
    end
  end

  assign unused_bits = ^{wdata, sel_full};

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: an 8-digit active-low instance checked against a
// scoreboard plus direct expectations, and a 1-digit active-high instance.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        frame_done;

  logic        cs1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;
  logic [7:0]  o_seg1;
  logic [0:0]  o_sel1;
  logic        frame_done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(8), .SCAN_W(3), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .addr(addr), .wdata(wdata),
    .o_seg(o_seg), .o_sel(o_sel), .frame_done(frame_done)
  );

  seg7_scan_ctrl #(.DIGITS(1), .SCAN_W(3), .BLINK_FRAMES(1), .ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .cs(cs1), .addr(addr1), .wdata(wdata1),
    .o_seg(o_seg1), .o_sel(o_sel1), .frame_done(frame_done1)
  );

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model of the 8-digit instance; each clock pushes {seg, sel, frame_done}.
  logic [2:0]  m_pre, m_idx;
  logic        m_phase;
  int          m_bcnt;
  logic [31:0] m_data_s, m_data_a;
  logic [7:0]  m_dp_s, m_dp_a, m_blank_s, m_blank_a, m_blink_s, m_blink_a;
  logic [2:0]  m_br_s, m_br_a;
  logic [16:0] sb [$];
  logic [16:0] exp_v;

  function automatic logic [16:0] model_out();
    logic       lit;
    logic [7:0] seg, sel;
    lit = !m_blank_a[m_idx] && !(m_blink_a[m_idx] && m_phase) && (m_pre <= m_br_a);
    seg = glyph[m_data_a[{m_idx, 2'b00} +: 4]];
    if (m_dp_a[m_idx]) seg[7] = 1'b0;
    sel = ~(8'b1 << m_idx);
    if (!lit) begin
      seg = 8'hFF;
      sel = 8'hFF;
    end
    return {seg, sel, (m_pre == 3'd7 && m_idx == 3'd7)};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pre <= 3'd0; m_idx <= 3'd0; m_phase <= 1'b0; m_bcnt <= 0;
      m_data_s <= '0; m_data_a <= '0; m_dp_s <= '0; m_dp_a <= '0;
      m_blank_s <= '0; m_blank_a <= '0; m_blink_s <= '0; m_blink_a <= '0;
      m_br_s <= 3'd7; m_br_a <= 3'd7;
      sb.delete();
    end else begin
      sb.push_back(model_out());
      m_pre <= m_pre + 3'd1;
      if (m_pre == 3'd7) m_idx <= m_idx + 3'd1;
      if (cs) begin
        case (addr)
          2'd0: m_data_s <= wdata;
          2'd1: m_dp_s <= wdata[7:0];
          2'd2: m_blank_s <= wdata[7:0];
          default: begin m_br_s <= wdata[2:0]; m_blink_s <= wdata[15:8]; end
        endcase
      end
      if (m_pre == 3'd7 && m_idx == 3'd7) begin
        m_data_a <= m_data_s; m_dp_a <= m_dp_s; m_blank_a <= m_blank_s;
        m_blink_a <= m_blink_s; m_br_a <= m_br_s;
        if (m_bcnt == 1) begin m_bcnt <= 0; m_phase <= ~m_phase; end
        else m_bcnt <= m_bcnt + 1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (!reset_n) exp_v = {8'hFF, 8'hFF, 1'b0};
    else if (sb.size() == 0) exp_v = 'x;
    else exp_v = sb.pop_front();
  endtask

  task automatic drive_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; addr = a; wdata = d;
  endtask

  task automatic drive_idle();
    cs = 1'b0; addr = 2'd0; wdata = '0;
  endtask

  task automatic test_reset();
    int fd_count;
    fd_count = 0;
    drive_idle();
    cs1 = 1'b0; addr1 = 2'd0; wdata1 = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (o_seg !== 8'hFF) begin errors++; $display("[TB] FAIL reset_seg got %h want ff", o_seg); end
    checks++; if (o_sel !== 8'hFF) begin errors++; $display("[TB] FAIL reset_sel got %h want ff", o_sel); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_fd got %b want 0", frame_done); end
    checks++; if ({o_seg1, o_sel1} !== 9'h000) begin errors++; $display("[TB] FAIL reset_dut1 got %h/%b want 00/0", o_seg1, o_sel1); end
    reset_n = 1'b1;
    for (int k = 0; k < 128; k++) begin
      step();
      checks++;
      if ({o_seg, o_sel, frame_done} !== exp_v) begin
        errors++;
        $display("[TB] FAIL sb_reset @%0t got %h/%h/%b want %h/%h/%b", $time, o_seg, o_sel, frame_done, exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
      checks++;
      if (o_sel !== ~(8'b1 << ((k / 8) % 8)) || o_seg !== 8'hC0 || frame_done !== (k % 64 == 63)) begin
        errors++;
        $display("[TB] FAIL scan_walk k=%0d got %h/%h/%b want %h/c0/%b", k, o_seg, o_sel, frame_done, ~(8'b1 << ((k / 8) % 8)), (k % 64 == 63));
      end
      if (frame_done) fd_count++;
    end
    checks++; if (fd_count != 2) begin errors++; $display("[TB] FAIL fd_count got %0d want 2", fd_count); end
  endtask

  task automatic test_data_commit();
    bit found;
    found = 1'b0;
    repeat (3) begin
      step();
      checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_commit_pre @%0t got %h/%h/%b want %h", $time, o_seg, o_sel, frame_done, exp_v); end
    end
    drive_write(2'd0, 32'h76543210);
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      drive_idle();
      checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_commit_wait @%0t got %h/%h/%b want %h", $time, o_seg, o_sel, frame_done, exp_v); end
      checks++; if (o_seg !== 8'hC0) begin errors++; $display("[TB] FAIL staged_hidden got %h want c0", o_seg); end
      if (frame_done) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL commit_timeout got no frame_done want pulse"); end
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 64; k++) begin
        step();
        checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_commit f=%0d k=%0d got %h/%h/%b want %h", f, k, o_seg, o_sel, frame_done, exp_v); end
        checks++;
        if (o_seg !== glyph[(f == 2 ? 8 : 0) + k / 8]) begin
          errors++;
          $display("[TB] FAIL frame_glyph f=%0d k=%0d got %h want %h", f, k, o_seg, glyph[(f == 2 ? 8 : 0) + k / 8]);
        end
        if (f == 0 && k == 62) drive_write(2'd0, 32'hFEDCBA98);
        else drive_idle();
      end
    end
  endtask

  task automatic test_masks();
    bit found;
    found = 1'b0;
    drive_write(2'd0, 32'h76543210); step();
    drive_write(2'd1, 32'h1);        step();
    drive_write(2'd2, 32'h80);       step();
    drive_idle();
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_masks_wait @%0t got %h/%h/%b want %h", $time, o_seg, o_sel, frame_done, exp_v); end
      if (frame_done) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL masks_timeout got no frame_done want pulse"); end
    for (int k = 0; k < 64; k++) begin
      logic [7:0] want_seg, want_sel;
      step();
      checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_masks k=%0d got %h/%h/%b want %h", k, o_seg, o_sel, frame_done, exp_v); end
      want_seg = (k / 8 == 0) ? 8'h40 : (k / 8 == 7) ? 8'hFF : glyph[k / 8];
      want_sel = (k / 8 == 7) ? 8'hFF : ~(8'b1 << (k / 8));
      checks++;
      if (o_seg !== want_seg || o_sel !== want_sel) begin
        errors++;
        $display("[TB] FAIL masks k=%0d got %h/%h want %h/%h", k, o_seg, o_sel, want_seg, want_sel);
      end
    end
  endtask

  task automatic test_bright();
    for (int pass = 0; pass < 2; pass++) begin
      int cnt [8];
      bit found;
      found = 1'b0;
      for (int d = 0; d < 8; d++) cnt[d] = 0;
      drive_write(2'd3, (pass == 0) ? 32'h0 : 32'h3);
      step();
      drive_idle();
      for (int n = 0; n < 200 && !found; n++) begin
        step();
        checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_bright_wait @%0t got %h/%h/%b want %h", $time, o_seg, o_sel, frame_done, exp_v); end
        if (frame_done) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("[TB] FAIL bright_timeout got no frame_done want pulse"); end
      for (int k = 0; k < 64; k++) begin
        step();
        checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_bright k=%0d got %h/%h/%b want %h", k, o_seg, o_sel, frame_done, exp_v); end
        if (o_sel !== 8'hFF) cnt[k / 8]++;
      end
      for (int d = 0; d < 8; d++) begin
        int want;
        want = (d == 7) ? 0 : ((pass == 0) ? 1 : 4);
        checks++; if (cnt[d] != want) begin errors++; $display("[TB] FAIL bright_duty pass=%0d d=%0d got %0d want %0d", pass, d, cnt[d], want); end
      end
    end
  endtask

  task automatic test_blink();
    bit found;
    bit vis1 [8];
    int on1, on0;
    found = 1'b0; on1 = 0; on0 = 0;
    drive_write(2'd3, 32'h0207); step();
    drive_write(2'd2, 32'h0);    step();
    drive_idle();
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_blink_wait @%0t got %h/%h/%b want %h", $time, o_seg, o_sel, frame_done, exp_v); end
      if (frame_done) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL blink_timeout got no frame_done want pulse"); end
    for (int f = 0; f < 8; f++) vis1[f] = 1'b0;
    for (int c = 0; c < 512; c++) begin
      step();
      checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_blink c=%0d got %h/%h/%b want %h", c, o_seg, o_sel, frame_done, exp_v); end
      if (o_sel === 8'hFD) vis1[c / 64] = 1'b1;
      if (o_sel === 8'hFE) on0++;
    end
    for (int f = 0; f < 8; f++) if (vis1[f]) on1++;
    for (int f = 0; f < 6; f++) begin
      checks++; if (vis1[f] == vis1[f + 2]) begin errors++; $display("[TB] FAIL blink_alt f=%0d got %b/%b want differing", f, vis1[f], vis1[f + 2]); end
    end
    checks++; if (on1 != 4) begin errors++; $display("[TB] FAIL blink_frames got %0d want 4", on1); end
    checks++; if (on0 != 64) begin errors++; $display("[TB] FAIL blink_other got %0d want 64", on0); end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    drive_write(2'd0, 32'h12345678); step();
    drive_write(2'd1, 32'hFF);       step();
    drive_write(2'd3, 32'h0F04);     step();
    drive_idle();
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      if (frame_done) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL mid_timeout got no frame_done want pulse"); end
    for (int k = 0; k < 44; k++) begin
      step();
      checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_mid k=%0d got %h/%h/%b want %h", k, o_seg, o_sel, frame_done, exp_v); end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({o_seg, o_sel, frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin errors++; $display("[TB] FAIL async_reset got %h/%h/%b want ff/ff/0", o_seg, o_sel, frame_done); end
    checks++; if ({o_seg1, o_sel1} !== 9'h000) begin errors++; $display("[TB] FAIL async_reset1 got %h/%b want 00/0", o_seg1, o_sel1); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      checks++; if ({o_seg, o_sel, frame_done} !== exp_v) begin errors++; $display("[TB] FAIL sb_after_reset k=%0d got %h/%h/%b want %h", k, o_seg, o_sel, frame_done, exp_v); end
      checks++;
      if (o_sel !== ~(8'b1 << (k / 8)) || o_seg !== 8'hC0 || frame_done !== (k == 63)) begin
        errors++;
        $display("[TB] FAIL after_reset k=%0d got %h/%h/%b want c0/%h/%b", k, o_seg, o_sel, frame_done, ~(8'b1 << (k / 8)), (k == 63));
      end
    end
  endtask

  task automatic test_single_digit();
    int fd_seen, pulses;
    fd_seen = 0; pulses = 0;
    step();
    checks++; if (o_seg1 !== 8'h3F || o_sel1 !== 1'b1) begin errors++; $display("[TB] FAIL single_init got %h/%b want 3f/1", o_seg1, o_sel1); end
    cs1 = 1'b1; addr1 = 2'd0; wdata1 = 32'hA;
    step();
    cs1 = 1'b0; wdata1 = '0;
    for (int n = 0; n < 40 && fd_seen < 2; n++) begin
      step();
      if (frame_done1) fd_seen++;
    end
    checks++; if (fd_seen != 2) begin errors++; $display("[TB] FAIL single_timeout got %0d pulses want 2", fd_seen); end
    for (int c = 0; c < 32; c++) begin
      step();
      checks++;
      if (o_seg1 !== 8'h77 || o_sel1 !== 1'b1 || frame_done1 !== (c % 8 == 7)) begin
        errors++;
        $display("[TB] FAIL single c=%0d got %h/%b/%b want 77/1/%b", c, o_seg1, o_sel1, frame_done1, (c % 8 == 7));
      end
      if (frame_done1) pulses++;
    end
    checks++; if (pulses != 4) begin errors++; $display("[TB] FAIL single_pulses got %0d want 4", pulses); end
  endtask

  initial begin
    test_reset();
    test_data_commit();
    test_masks();
    test_bright();
    test_blink();
    test_reset_mid();
    test_single_digit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
